// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: enable/flush strobes for all pipeline registers, FSM for dcache wait and halt drain.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_EX_MEM,
    input  logic             dWEN_EX_MEM,
    input  logic             dREN_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             branch_taken_EX_MEM,
    input  logic             halt_MEM_WB,
    output logic             pc_enable,
    output logic             enable_IF_ID,
    output logic             enable_ID_EX,
    output logic             enable_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             halted,
    output logic [1:0]       state_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] squash_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    state_t state_r;
    state_t state_nxt_s;
    logic   halted_r;
    logic   dmem_miss_s;
    logic   load_use_s;
    logic   flow_s;
    logic   squash_s;

    assign dmem_miss_s = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;
    assign load_use_s  = dREN_ID_EX & (Rt_ID_EX != 5'd0) &
                         ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

    assign state_o = state_r;
    // Reset masks the halt flag in the reset cycle itself, not only after the edge.
    assign halted  = halted_r & ~RST;

    // Next-state selection and strobe generation; reset forces bubbles everywhere.
    always_comb begin
        pc_enable     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        flush_IF_ID   = 1'b0;
        flush_ID_EX   = 1'b0;
        flush_EX_MEM  = 1'b0;
        state_nxt_s   = state_r;
        flow_s        = 1'b0;
        squash_s      = 1'b0;

        if (RST) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            state_nxt_s  = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_MEM_WB) begin
                        state_nxt_s = ST_HALT;
                    end else if (dmem_miss_s) begin
                        state_nxt_s = ST_DWAIT;
                    end else begin
                        flow_s = 1'b1;
                    end
                end
                ST_DWAIT: begin
                    if (dhit) begin
                        state_nxt_s = ST_RUN;
                        flow_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_DWAIT;
                    end
                end
                ST_HALT: begin
                    state_nxt_s = ST_HALT;
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end

        // Normal flow: branch squash beats load-use, which beats the icache bubble.
        if (flow_s) begin
            enable_IF_ID  = 1'b1;
            enable_ID_EX  = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
            if (branch_taken_EX_MEM) begin
                pc_enable    = 1'b1;
                flush_IF_ID  = 1'b1;
                flush_ID_EX  = 1'b1;
                flush_EX_MEM = 1'b1;
                squash_s     = 1'b1;
            end else if (load_use_s) begin
                enable_IF_ID = 1'b0;
                flush_ID_EX  = 1'b1;
            end else if (!ihit) begin
                flush_IF_ID = 1'b1;
            end else begin
                pc_enable = 1'b1;
            end
        end else begin
            squash_s = 1'b0;
        end
    end

    // State and halt flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            halted_r <= (state_nxt_s == ST_HALT);
        end
    end

`ifdef HAZARD_STATS_EN
    logic stall_inc_s;

    assign stall_inc_s = ~pc_enable & ((state_r == ST_RUN) | (state_r == ST_DWAIT));

    // Saturating stall and squash counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles <= {CNT_W{1'b0}};
            squash_count <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (squash_s && (squash_count != {CNT_W{1'b1}})) begin
                squash_count <= squash_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                squash_count <= squash_count;
            end
        end
    end
`endif

endmodule
